// File: rtl/nexi_uart_tx_sequencer_pkg.sv
// Shared definitions for the nexi UART TX sequencer: slave register map, ISR bits, FSM states.
package nexi_uart_tx_sequencer_pkg;

    localparam logic [2:0] ADDR_THR = 3'd1;
    localparam logic [2:0] ADDR_IER = 3'd2;
    localparam logic [2:0] ADDR_ISR = 3'd3;

    localparam int         ISR_TX_BIT = 0;
    localparam logic [7:0] IER_TX_EN  = 8'h01;

    typedef enum logic [2:0] {
        ST_INIT_IER,
        ST_INIT_REL,
        ST_IDLE,
        ST_WR_THR,
        ST_WR_REL,
        ST_WAIT_IRQ,
        ST_RD_ISR,
        ST_RD_REL
    } state_t;

    function automatic logic is_bus_state(input state_t s);
        return (s == ST_INIT_IER) || (s == ST_WR_THR) || (s == ST_RD_ISR);
    endfunction

endpackage

// File: rtl/nexi_uart_tx_sequencer_fifo.sv
// Synchronous FIFO with registered full/empty/level flags; pushes into a full FIFO are dropped.
module nexi_sync_fifo #(
    parameter  int WIDTH = 8,
    parameter  int DEPTH = 8,
    localparam int AW    = $clog2(DEPTH),
    localparam int LW    = AW + 1
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             push_i,
    input  logic [WIDTH-1:0] push_data_i,
    input  logic             pop_i,
    output logic [WIDTH-1:0] pop_data_o,
    output logic             full_o,
    output logic             empty_o,
    output logic [LW-1:0]    level_o
);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [LW-1:0]    level_q, level_d;
    logic             full_q, full_d;
    logic             empty_q, empty_d;
    logic             push_ok, pop_ok;

    assign push_ok = push_i && !full_q;
    assign pop_ok  = pop_i && !empty_q;

    always_comb begin
        wr_ptr_d = push_ok ? wr_ptr_q + AW'(1) : wr_ptr_q;
        rd_ptr_d = pop_ok  ? rd_ptr_q + AW'(1) : rd_ptr_q;
        level_d  = level_q;
        if (push_ok && !pop_ok) begin
            level_d = level_q + LW'(1);
        end else if (pop_ok && !push_ok) begin
            level_d = level_q - LW'(1);
        end
        full_d  = (level_d == LW'(DEPTH));
        empty_d = (level_d == '0);
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
            full_q   <= 1'b0;
            empty_q  <= 1'b1;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
            full_q   <= full_d;
            empty_q  <= empty_d;
        end
    end

    // Storage has no reset; only entries between the pointers are ever read.
    always_ff @(posedge clk_i) begin
        if (push_ok) begin
            mem_q[wr_ptr_q] <= push_data_i;
        end
    end

    assign pop_data_o = mem_q[rd_ptr_q];
    assign full_o     = full_q;
    assign empty_o    = empty_q;
    assign level_o    = level_q;

endmodule

// File: rtl/nexi_uart_tx_sequencer.sv
// Wishbone master that drains a byte FIFO into the nexi UART: THR write, wait for irq, ISR read.
module nexi_uart_tx_sequencer
    import nexi_uart_tx_sequencer_pkg::*;
#(
    parameter int DEPTH   = 8,
    parameter int TIMEOUT = 65535,
    parameter int TW      = 16
) (
    input  logic                   clk_i,
    input  logic                   rst_ni,
    input  logic                   push_i,
    input  logic [7:0]             push_data_i,
    output logic                   full_o,
    output logic                   empty_o,
    output logic [$clog2(DEPTH):0] level_o,
    output logic                   busy_o,
    output logic                   error_o,
    output logic                   wb_cyc_o,
    output logic                   wb_stb_o,
    output logic                   wb_we_o,
    output logic [2:0]             wb_addr_o,
    output logic [7:0]             wb_data_o,
    input  logic [7:0]             wb_data_i,
    input  logic                   wb_ack_i,
    input  logic                   irq_i
);

    state_t        state_q, state_d;
    logic [TW-1:0] cnt_q, cnt_d;
    logic [7:0]    byte_q, byte_d;
    logic [7:0]    isr_q, isr_d;
    logic          cyc_q, cyc_d;
    logic          we_q, we_d;
    logic [2:0]    addr_q, addr_d;
    logic [7:0]    wdata_q, wdata_d;
    logic          busy_q, busy_d;

    logic          fifo_pop;
    logic [7:0]    fifo_data;
    logic          fifo_empty;
    logic          counting;
    logic          timeout_hit;
    logic          bus_ack;
    logic          isr_unused;

    nexi_sync_fifo #(
        .WIDTH (8),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk_i       (clk_i),
        .rst_ni      (rst_ni),
        .push_i      (push_i),
        .push_data_i (push_data_i),
        .pop_i       (fifo_pop),
        .pop_data_o  (fifo_data),
        .full_o      (full_o),
        .empty_o     (fifo_empty),
        .level_o     (level_o)
    );

    assign counting    = (state_q != ST_IDLE);
    assign timeout_hit = counting && (cnt_q == TW'(TIMEOUT));
    assign bus_ack     = wb_ack_i && cyc_q;

    // Release states wait for ack to drop because the slave only lowers it after cyc/stb fall.
    always_comb begin
        state_d  = state_q;
        byte_d   = byte_q;
        isr_d    = isr_q;
        fifo_pop = 1'b0;
        case (state_q)
            ST_INIT_IER: if (bus_ack) state_d = ST_INIT_REL;
            ST_INIT_REL: if (!wb_ack_i) state_d = ST_IDLE;
            ST_IDLE: begin
                if (!fifo_empty) begin
                    fifo_pop = 1'b1;
                    byte_d   = fifo_data;
                    state_d  = ST_WR_THR;
                end
            end
            ST_WR_THR:   if (bus_ack) state_d = ST_WR_REL;
            ST_WR_REL:   if (!wb_ack_i) state_d = ST_WAIT_IRQ;
            ST_WAIT_IRQ: if (irq_i) state_d = ST_RD_ISR;
            ST_RD_ISR: begin
                if (bus_ack) begin
                    isr_d   = wb_data_i;
                    state_d = ST_RD_REL;
                end
            end
            ST_RD_REL: begin
                if (!wb_ack_i) begin
                    state_d = isr_q[ISR_TX_BIT] ? ST_IDLE : ST_WAIT_IRQ;
                end
            end
            default: state_d = ST_INIT_IER;
        endcase

        // A stuck IER write is abandoned rather than retried; any other abort drops the byte.
        if (timeout_hit) begin
            state_d = (state_q == ST_INIT_IER) ? ST_INIT_REL : ST_IDLE;
        end

        cnt_d = (counting && (state_d == state_q)) ? cnt_q + TW'(1) : '0;

        cyc_d   = is_bus_state(state_d);
        we_d    = 1'b0;
        addr_d  = '0;
        wdata_d = '0;
        case (state_d)
            ST_INIT_IER: begin
                we_d    = 1'b1;
                addr_d  = ADDR_IER;
                wdata_d = IER_TX_EN;
            end
            ST_WR_THR: begin
                we_d    = 1'b1;
                addr_d  = ADDR_THR;
                wdata_d = byte_d;
            end
            ST_RD_ISR: addr_d = ADDR_ISR;
            default: ;
        endcase

        busy_d = (state_d != ST_IDLE);
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= ST_INIT_IER;
            cnt_q   <= '0;
            byte_q  <= '0;
            isr_q   <= '0;
            cyc_q   <= 1'b0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            byte_q  <= byte_d;
            isr_q   <= isr_d;
            cyc_q   <= cyc_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            busy_q  <= busy_d;
        end
    end

    // Only the TX-done bit steers the FSM; the rest of the ISR is captured but not acted on.
    assign isr_unused = ^isr_q[7:1];

    assign empty_o   = fifo_empty;
    assign busy_o    = busy_q;
    assign error_o   = timeout_hit;
    assign wb_cyc_o  = cyc_q;
    assign wb_stb_o  = cyc_q;
    assign wb_we_o   = we_q;
    assign wb_addr_o = addr_q;
    assign wb_data_o = wdata_q;

endmodule

// File: tb/tb_nexi_uart_tx_sequencer.sv
// Directed bench for nexi_uart_tx_sequencer with a small Wishbone UART slave model.
module tb_nexi_uart_tx_sequencer;

    localparam int DEPTH   = 8;
    localparam int TIMEOUT = 100;
    localparam int TW      = 16;

    typedef struct packed {
        logic       we;
        logic [2:0] addr;
        logic [7:0] data;
    } busEntry_t;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       push;
    logic [7:0] pushData;
    logic       full_o, empty_o, busy_o, error_o;
    logic [3:0] level_o;
    logic       wb_cyc, wb_stb, wb_we;
    logic [2:0] wb_addr;
    logic [7:0] wb_dat_o;

    // Slave model state
    logic       ackR = 1'b0;
    logic       irqR = 1'b0;
    logic [7:0] rdata = 8'h00;
    logic       prevCyc = 1'b0;
    logic       irqKick = 1'b0;
    int         cycleNum = 0;
    int         holdCnt = 0;
    int         irqCountdown = -1;
    int         errCount = 0;
    int         errCycle = 0;
    int         violations = 0;
    int         ackEnable = 1;
    int         ackHold = 0;
    int         irqEnable = 1;
    int         irqDelay = 20;

    busEntry_t  logQ[$];
    int         logCycle[$];
    logic [7:0] respQ[$];

    int compared = 0;
    int mismatched = 0;

    always #5 clk = ~clk;

    nexi_uart_tx_sequencer #(
        .DEPTH   (DEPTH),
        .TIMEOUT (TIMEOUT),
        .TW      (TW)
    ) dut (
        .clk_i       (clk),
        .rst_ni      (rst_n),
        .push_i      (push),
        .push_data_i (pushData),
        .full_o      (full_o),
        .empty_o     (empty_o),
        .level_o     (level_o),
        .busy_o      (busy_o),
        .error_o     (error_o),
        .wb_cyc_o    (wb_cyc),
        .wb_stb_o    (wb_stb),
        .wb_we_o     (wb_we),
        .wb_addr_o   (wb_addr),
        .wb_data_o   (wb_dat_o),
        .wb_data_i   (rdata),
        .wb_ack_i    (ackR),
        .irq_i       (irqR)
    );

    // UART slave: 1-cycle ack, ack held ackHold cycles after cyc drops, irq raised irqDelay after a THR write.
    always @(posedge clk) begin
        cycleNum <= cycleNum + 1;
        prevCyc  <= wb_cyc;
        if (wb_cyc && !prevCyc && ackR) violations <= violations + 1;
        if (error_o) begin
            errCount <= errCount + 1;
            errCycle <= cycleNum;
        end
        if (!rst_n) begin
            ackR         <= 1'b0;
            irqR         <= 1'b0;
            irqCountdown <= -1;
            holdCnt      <= 0;
        end else begin
            if (irqCountdown > 0) begin
                irqCountdown <= irqCountdown - 1;
            end else if (irqCountdown == 0) begin
                irqR         <= 1'b1;
                irqCountdown <= -1;
            end
            if (irqKick) irqR <= 1'b1;
            if (wb_cyc && wb_stb && !ackR && (ackEnable != 0)) begin
                ackR <= 1'b1;
                if (!wb_we) begin
                    if (respQ.size() > 0) rdata <= respQ.pop_front();
                    else                  rdata <= 8'h01;
                end
            end else if (wb_cyc && wb_stb && ackR) begin
                logQ.push_back({wb_we, wb_addr, (wb_we ? wb_dat_o : rdata)});
                logCycle.push_back(cycleNum);
                holdCnt <= ackHold;
                if (wb_we && wb_addr == 3'd1 && irqEnable != 0) irqCountdown <= irqDelay;
                if (!wb_we && wb_addr == 3'd3) begin
                    irqR <= 1'b0;
                    if (!rdata[0]) irqCountdown <= irqDelay;
                end
            end else if (ackR && !wb_cyc) begin
                if (holdCnt == 0) ackR <= 1'b0;
                else              holdCnt <= holdCnt - 1;
            end
        end
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        compared++;
        if (observed !== expected) begin
            mismatched++;
            $display("[TB] FAIL %s: observed 0x%0h, expected 0x%0h", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input logic [7:0] b);
        push     = 1'b1;
        pushData = b;
        @(negedge clk);
        push     = 1'b0;
    endtask

    task automatic waitLog(input string tag, input int n);
        int budget = 2000;
        while (logQ.size() < n && budget > 0) begin
            @(negedge clk);
            budget--;
        end
        checkOutput(tag, logQ.size(), n);
    endtask

    task automatic waitIdle(input string tag);
        int budget = 2000;
        while (busy_o && budget > 0) begin
            @(negedge clk);
            budget--;
        end
        checkOutput(tag, busy_o, 1'b0);
    endtask

    task automatic checkEntry(input string tag, input int idx, input logic we, input logic [2:0] addr,
                              input logic [7:0] data);
        logic [11:0] got;
        logic [11:0] exp;
        got = (idx < logQ.size()) ? logQ[idx] : 12'hfff;
        exp = {we, addr, data};
        checkOutput(tag, 32'(got), 32'(exp));
    endtask

    initial begin
        int base;
        int errBase;
        int violBase;
        int budget;

        push     = 1'b0;
        pushData = 8'h00;
        rst_n    = 1'b0;
        repeat (3) @(negedge clk);

        // Reset values
        checkOutput("rst_cyc", wb_cyc, 1'b0);
        checkOutput("rst_stb", wb_stb, 1'b0);
        checkOutput("rst_we", wb_we, 1'b0);
        checkOutput("rst_busy", busy_o, 1'b0);
        checkOutput("rst_error", error_o, 1'b0);
        checkOutput("rst_full", full_o, 1'b0);
        checkOutput("rst_empty", empty_o, 1'b1);
        checkOutput("rst_level", level_o, 4'd0);

        // IER init: exactly one write of 0x01 to address 2
        rst_n = 1'b1;
        waitLog("ier_wait", 1);
        checkEntry("ier_entry", 0, 1'b1, 3'd2, 8'h01);
        waitIdle("ier_idle");
        checkOutput("ier_count", logQ.size(), 1);
        checkOutput("ier_empty", empty_o, 1'b1);

        // Three bytes, each written then cleared with one ISR read
        base    = logQ.size();
        errBase = errCount;
        applyStimulus(8'h41);
        applyStimulus(8'h42);
        applyStimulus(8'h43);
        waitLog("seq_wait", base + 6);
        for (int i = 0; i < 3; i++) begin
            checkEntry($sformatf("seq_thr%0d", i), base + 2 * i, 1'b1, 3'd1, 8'h41 + 8'(i));
            checkEntry($sformatf("seq_isr%0d", i), base + 2 * i + 1, 1'b0, 3'd3, 8'h01);
        end
        waitIdle("seq_idle");
        checkOutput("seq_no_error", errCount - errBase, 0);
        checkOutput("seq_count", logQ.size(), base + 6);

        // Overflow while the sequencer sits in WAIT_IRQ
        irqEnable = 0;
        base      = logQ.size();
        errBase   = errCount;
        applyStimulus(8'h50);
        waitLog("ovf_first", base + 1);
        checkEntry("ovf_thr50", base, 1'b1, 3'd1, 8'h50);
        for (int i = 0; i < 9; i++) applyStimulus(8'h51 + 8'(i));
        checkOutput("ovf_full", full_o, 1'b1);
        checkOutput("ovf_level", level_o, 4'd8);
        checkOutput("ovf_not_empty", empty_o, 1'b0);
        irqEnable = 1;
        irqDelay  = 5;
        irqKick   = 1'b1;
        @(negedge clk);
        irqKick   = 1'b0;
        waitLog("ovf_drain", base + 18);
        checkEntry("ovf_isr50", base + 1, 1'b0, 3'd3, 8'h01);
        for (int i = 0; i < 8; i++) begin
            checkEntry($sformatf("ovf_thr%0d", i), base + 2 + 2 * i, 1'b1, 3'd1, 8'h51 + 8'(i));
        end
        waitIdle("ovf_idle");
        checkOutput("ovf_ninth_dropped", logQ.size(), base + 18);
        checkOutput("ovf_empty", empty_o, 1'b1);
        checkOutput("ovf_level0", level_o, 4'd0);
        checkOutput("ovf_no_error", errCount - errBase, 0);

        // RX-only interrupt first, TX-done second
        irqDelay = 20;
        respQ.push_back(8'h02);
        respQ.push_back(8'h01);
        base = logQ.size();
        applyStimulus(8'h44);
        applyStimulus(8'h45);
        waitLog("rx_wait", base + 5);
        checkEntry("rx_thr44", base, 1'b1, 3'd1, 8'h44);
        checkEntry("rx_isr_rx", base + 1, 1'b0, 3'd3, 8'h02);
        checkEntry("rx_isr_tx", base + 2, 1'b0, 3'd3, 8'h01);
        checkEntry("rx_thr45", base + 3, 1'b1, 3'd1, 8'h45);
        checkEntry("rx_isr45", base + 4, 1'b0, 3'd3, 8'h01);
        waitIdle("rx_idle");

        // Timeout in WAIT_IRQ: one error pulse, byte dropped, next byte still sent
        irqEnable = 0;
        base      = logQ.size();
        errBase   = errCount;
        applyStimulus(8'h60);
        applyStimulus(8'h61);
        waitLog("to_first", base + 1);
        checkEntry("to_thr60", base, 1'b1, 3'd1, 8'h60);
        budget = 400;
        while (errCount == errBase && budget > 0) begin
            @(negedge clk);
            budget--;
        end
        checkOutput("to_err_seen", errCount - errBase, 1);
        checkOutput("to_err_delay", errCycle - logCycle[base], 103);
        waitLog("to_second", base + 2);
        checkEntry("to_thr61", base + 1, 1'b1, 3'd1, 8'h61);
        checkOutput("to_err_once", errCount - errBase, 1);
        irqEnable = 1;
        irqKick   = 1'b1;
        @(negedge clk);
        irqKick   = 1'b0;
        waitLog("to_isr", base + 3);
        checkEntry("to_isr61", base + 2, 1'b0, 3'd3, 8'h01);
        waitIdle("to_idle");
        checkOutput("to_err_final", errCount - errBase, 1);

        // Slave holds ack 3 cycles after cyc drops
        ackHold  = 3;
        irqDelay = 5;
        violBase = violations;
        base     = logQ.size();
        applyStimulus(8'h70);
        applyStimulus(8'h71);
        waitLog("hold_wait", base + 4);
        checkEntry("hold_thr70", base, 1'b1, 3'd1, 8'h70);
        checkEntry("hold_isr70", base + 1, 1'b0, 3'd3, 8'h01);
        checkEntry("hold_thr71", base + 2, 1'b1, 3'd1, 8'h71);
        checkEntry("hold_isr71", base + 3, 1'b0, 3'd3, 8'h01);
        waitIdle("hold_idle");
        checkOutput("hold_no_overlap", violations - violBase, 0);
        checkOutput("hold_gap", (logCycle[base + 1] - logCycle[base]) >= 6, 1'b1);

        // Reset in the middle of a THR write
        ackHold   = 0;
        ackEnable = 0;
        applyStimulus(8'h72);
        budget = 50;
        while (!(wb_cyc && wb_we && wb_addr == 3'd1) && budget > 0) begin
            @(negedge clk);
            budget--;
        end
        checkOutput("mid_thr_req", wb_cyc && wb_we && wb_addr == 3'd1, 1'b1);
        rst_n = 1'b0;
        #1;
        checkOutput("mid_cyc", wb_cyc, 1'b0);
        checkOutput("mid_stb", wb_stb, 1'b0);
        checkOutput("mid_busy", busy_o, 1'b0);
        checkOutput("mid_empty", empty_o, 1'b1);
        checkOutput("mid_level", level_o, 4'd0);
        repeat (2) @(negedge clk);
        ackEnable = 1;
        base      = logQ.size();
        rst_n     = 1'b1;
        waitLog("mid_ier", base + 1);
        checkEntry("mid_ier_entry", base, 1'b1, 3'd2, 8'h01);
        waitIdle("mid_idle");
        checkOutput("mid_no_thr", logQ.size(), base + 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/nexi_uart_tx_sequencer.md
Name: nexi_uart_tx_sequencer

Overview:
- Wishbone master that feeds the nexi 16550-style UART slave from a local byte FIFO.
- Enables the slave's TX interrupt after reset, then runs one sequence per queued byte: write THR, wait for `irq_i`, read ISR to clear it.
- Lets a producer stream bytes with a push/full handshake and never touch the UART register map.
- Sits between a producer (CPU shim, debug logger) and the UART's Wishbone port.

Parameters:
- DEPTH, 8, FIFO entries; power of two, 2..256.
- TIMEOUT, 65535, max cycles spent waiting in any single wait state before abort.
- TW, 16, timeout counter width; TIMEOUT must fit in TW bits.

Ports:
- clk_i  in  1  system clock
- rst_ni  in  1  reset, asynchronous, active-low
- push_i  in  1  write push_data_i into FIFO
- push_data_i  in  8  byte to send
- full_o  out  1  FIFO full
- empty_o  out  1  FIFO empty
- level_o  out  $clog2(DEPTH)+1  FIFO occupancy
- busy_o  out  1  high in every state except IDLE
- error_o  out  1  one-cycle pulse on timeout abort
- wb_cyc_o  out  1  Wishbone cycle
- wb_stb_o  out  1  Wishbone strobe
- wb_we_o  out  1  write enable
- wb_addr_o  out  3  register address
- wb_data_o  out  8  write data
- wb_data_i  in  8  read data
- wb_ack_i  in  1  slave acknowledge
- irq_i  in  1  slave interrupt, level

Behaviour:
- Clocking and reset: one clock `clk_i`; `rst_ni` asynchronous active-low.
- Reset values: all outputs 0, except `empty_o`=1 and `level_o`=0. FIFO pointers cleared. State=INIT_IER.
- Register map (slave): RBR=0, THR=1, IER=2, ISR=3. ISR bit0=TX done, bit1=RX.
- Bus cycle: `cyc_o`/`stb_o`/`we_o`/`addr_o`/`data_o` are registered and stable until `wb_ack_i`=1.
  - On ack, drop `cyc`/`stb`/`we` the next cycle.
  - Enter a release state; leave it only when `wb_ack_i`=0, because the slave drops ack only after cyc/stb are low.
- States and transitions:
  - INIT_IER: write addr 2, data 8'h01; ack -> INIT_REL.
  - INIT_REL: ack low -> IDLE.
  - IDLE: if !empty, pop head into byte register -> WR_THR. Bus request appears the cycle after the pop.
  - WR_THR: write addr 1, data=byte; ack -> WR_REL.
  - WR_REL: ack low -> WAIT_IRQ.
  - WAIT_IRQ: `irq_i`=1 -> RD_ISR.
  - RD_ISR: read addr 3; on ack, capture `wb_data_i` -> RD_REL.
  - RD_REL: ack low; if captured bit0=1 -> IDLE, else -> WAIT_IRQ. An RX-only interrupt is consumed and TX is still awaited.
- Timeout:
  - Counter clears on every state change and increments in WR_THR, WAIT_IRQ, RD_ISR, INIT_IER and all *_REL states.
  - When it reaches TIMEOUT: deassert bus, pulse `error_o`, byte is dropped.
  - Destination: IDLE, or INIT_REL→IDLE from INIT_IER (IER is not retried).
- FIFO:
  - Push is accepted iff `push_i` && !`full_o`; push while full is ignored and the data is lost.
  - Pop happens only in IDLE.
  - Simultaneous push and pop: `level` unchanged, both take effect.
  - Pointers wrap modulo DEPTH.
  - `full_o`/`empty_o`/`level_o` are registered, valid the cycle after the change.
- Reset mid-operation: immediate return to reset values; any in-flight bus cycle is abandoned with `cyc`=0.
- Throughput: minimum 8 cycles per byte plus slave TX time.

Decomposition:
- nexi_uart_defs.vh: register addresses (RBR/THR/IER/ISR), ISR bit masks, state encodings.
- Sub-module nexi_sync_fifo, parameterised by width (8) and DEPTH: push/pop/full/empty/level, same clock and reset.
- The FSM and timeout counter stay in the top module.

Test Plan:
- Reset release with slave model acking in 1 cycle -> single write addr 2 data 8'h01; `busy_o` falls once ack is low; FIFO empty.
- Push 8'h41, 8'h42, 8'h43; model raises irq 20 cycles after each THR write, ISR reads 8'h01 -> THR writes 41, 42, 43 in order; each followed by exactly one ISR read; `error_o` never pulses.
- Push 9 bytes back-to-back with DEPTH=8 while sequencer is held in WAIT_IRQ -> `full_o`=1 after 8; 9th byte absent from the THR stream; `level_o`=8.
- First ISR read returns 8'h02, second returns 8'h01 -> two ISR reads; next THR write only after the second.
- Model never asserts irq, TIMEOUT=100 -> `error_o` pulses once 100 cycles after WAIT_IRQ entry; next queued byte is written.
- Slave holds ack high 3 cycles after cyc drops -> next cycle starts only after ack low. Then assert `rst_ni` low mid-WR_THR -> `cyc_o` low immediately; INIT_IER write repeats after release.
